mantissa_aligner: RTL and testbench

Two-stage pipelined right-shift aligner for the dual FMA datapath: the counterpart of the leading-one normalizer. Takes a mantissa at its own exponent, computes the distance to a reference (larger) exponent, and right-shifts into a guard-extended field with a sticky bit so the adder sees operands aligned to a common exponent. It sits between operand unpack and the mantissa adder. Valid/ready on both sides.

---
 rtl/mantissa_aligner_if.sv | 32 +++
 rtl/mantissa_aligner.sv | 117 +++++++++++
 tb/tb_mantissa_aligner.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mantissa_aligner_if.sv
// Handshake bundle for the mantissa aligner: operand beat in, aligned beat out.
// slave is the aligner's view, master is the producer/consumer view.
interface mantissa_aligner_if #(
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 5,
    parameter int GUARD_BITS = 3
);
    localparam int OUT_W = MAN_WIDTH + GUARD_BITS;

    logic                 in_valid;
    logic                 in_ready;
    logic [MAN_WIDTH-1:0] in_man;
    logic [EXP_WIDTH-1:0] in_exp;
    logic [EXP_WIDTH-1:0] ref_exp;

    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_man;
    logic                 out_sticky;
    logic [EXP_WIDTH-1:0] out_exp;
    logic                 out_inv;

    modport slave (
        input  in_valid, in_man, in_exp, ref_exp, out_ready,
        output in_ready, out_valid, out_man, out_sticky, out_exp, out_inv
    );

    modport master (
        output in_valid, in_man, in_exp, ref_exp, out_ready,
        input  in_ready, out_valid, out_man, out_sticky, out_exp, out_inv
    );
endinterface

// File: rtl/mantissa_aligner.sv
// Right-shift aligner: mantissa moved to ref_exp into a guard-extended field; sticky only with ALIGNER_STICKY_EN.
// Latency 2 cycles (S1 exponent diff, S2 shift), 1 beat/cycle.
// Backpressure: out_ready stalls S2, S1 behind it; in_ready drops only when both stages hold beats.
module mantissa_aligner #(
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 5,
    parameter int GUARD_BITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    mantissa_aligner_if.slave   bus
);
    localparam int OUT_W = MAN_WIDTH + GUARD_BITS;
    localparam int SH_W  = $clog2(OUT_W + 1);

    logic                 v1;
    logic                 v2;
    logic                 load1;
    logic                 load2;

    logic [MAN_WIDTH-1:0] man1;
    logic [SH_W-1:0]      shamt1;
    logic                 inv1;
    logic [EXP_WIDTH-1:0] exp1;

    logic [EXP_WIDTH:0]   diff;
    logic [SH_W-1:0]      shamt_d;
    logic                 inv_d;
    logic [EXP_WIDTH-1:0] exp_d;

    logic [OUT_W-1:0]     ext;
    logic [OUT_W-1:0]     man_d;
    logic                 sticky_d;

    logic [OUT_W-1:0]     man2;
    logic                 sticky2;
    logic [EXP_WIDTH-1:0] exp2;
    logic                 inv2;

    assign load2        = !v2 || bus.out_ready;
    assign load1        = !v1 || load2;
    assign bus.in_ready = !v1 || !v2 || bus.out_ready;

    // Borrow out of the widened subtraction marks in_exp above ref_exp.
    always_comb begin
        diff    = {1'b0, bus.ref_exp} - {1'b0, bus.in_exp};
        shamt_d = '0;
        inv_d   = 1'b0;
        exp_d   = bus.ref_exp;
        if (diff[EXP_WIDTH]) begin
            inv_d = 1'b1;
            exp_d = bus.in_exp;
        end else if (32'(diff) >= OUT_W) begin
            shamt_d = SH_W'(OUT_W);
        end else begin
            shamt_d = SH_W'(diff);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            man1   <= '0;
            shamt1 <= '0;
            inv1   <= 1'b0;
            exp1   <= '0;
        end else if (load1) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                man1   <= bus.in_man;
                shamt1 <= shamt_d;
                inv1   <= inv_d;
                exp1   <= exp_d;
            end
        end
    end

    assign ext   = {man1, {GUARD_BITS{1'b0}}};
    assign man_d = ext >> shamt1;

`ifdef ALIGNER_STICKY_EN
    localparam logic [OUT_W:0] ONE = 1;
    logic [OUT_W:0] mask;

    // A full-width shift wraps the mask to all ones, covering the whole mantissa.
    always_comb begin
        mask     = (ONE << shamt1) - ONE;
        sticky_d = |(ext & mask[OUT_W-1:0]);
    end
`else
    assign sticky_d = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2      <= 1'b0;
            man2    <= '0;
            sticky2 <= 1'b0;
            exp2    <= '0;
            inv2    <= 1'b0;
        end else if (load2) begin
            v2 <= v1;
            if (v1) begin
                man2    <= man_d;
                sticky2 <= sticky_d;
                exp2    <= exp1;
                inv2    <= inv1;
            end
        end
    end

    assign bus.out_valid  = v2;
    assign bus.out_man    = man2;
    assign bus.out_sticky = sticky2;
    assign bus.out_exp    = exp2;
    assign bus.out_inv    = inv2;
endmodule

// File: tb/tb_mantissa_aligner.sv
// Random and directed stimulus against an arithmetic reference model with a beat queue.
module tb_mantissa_aligner;
    localparam int MW = 8;
    localparam int EW = 5;
    localparam int GB = 3;
    localparam int OW = MW + GB;
`ifdef ALIGNER_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [OW-1:0] man;
        logic          sticky;
        logic [EW-1:0] exp;
        logic          inv;
        int            acc;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   mode = 0;
    beat_t q[$];

    mantissa_aligner_if #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .GUARD_BITS(GB)) bus ();

    mantissa_aligner #(.MAN_WIDTH(MW), .EXP_WIDTH(EW), .GUARD_BITS(GB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Alignment as arithmetic: scale by 2^GB, then integer divide by 2^shift.
    function automatic beat_t model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                    input logic [EW-1:0] r, input int acc);
        beat_t  x;
        longint d;
        longint sh;
        longint full;
        d    = longint'(r) - longint'(e);
        full = longint'(m) * (longint'(1) << GB);
        if (d < 0) begin
            sh    = 0;
            x.inv = 1'b1;
            x.exp = e;
        end else begin
            sh    = (d > OW) ? OW : d;
            x.inv = 1'b0;
            x.exp = r;
        end
        x.man    = OW'(full >> sh);
        x.sticky = STICKY && ((full % (longint'(1) << sh)) != 0);
        x.acc    = acc;
        return x;
    endfunction

    // out_ready: 0 = always high, 1 = random with low gaps of 3+ cycles, 2 = held low.
    initial begin
        bit cur;
        int hold;
        cur = 1'b1;
        hold = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (mode == 0) begin
                cur = 1'b1;
            end else if (mode == 2) begin
                cur = 1'b0;
            end else if (hold > 0) begin
                hold--;
            end else begin
                cur = !cur;
                hold = cur ? $urandom_range(0, 3) : $urandom_range(2, 5);
            end
            bus.out_ready = cur;
        end
    end

    // Compare process: the oldest beat must be on the output once two edges have passed since it was taken.
    always @(negedge clk) begin
        bit ev;
        if (rst) begin
            q.delete();
            n_in = 0;
            n_out = 0;
        end else begin
            ev = (q.size() > 0) && (cyc >= q[0].acc + 2);
            check("in_ready", 64'(bus.in_ready), 64'((q.size() < 2) || bus.out_ready));
            check("out_valid", 64'(bus.out_valid), 64'(ev));
            if (ev && bus.out_valid) begin
                check("out_man", 64'(bus.out_man), 64'(q[0].man));
                check("out_sticky", 64'(bus.out_sticky), 64'(q[0].sticky));
                check("out_exp", 64'(bus.out_exp), 64'(q[0].exp));
                check("out_inv", 64'(bus.out_inv), 64'(q[0].inv));
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    n_out++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_man, bus.in_exp, bus.ref_exp, cyc));
                n_in++;
            end
        end
    end

    task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic [EW-1:0] r);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_man = m;
        bus.in_exp = e;
        bus.ref_exp = r;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) check("send_timeout", 64'(t), 64'(0));
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 500) begin
            t++;
            @(negedge clk);
        end
        check("drain_queue", 64'(q.size()), 64'(0));
        @(posedge clk);
        #2;
    endtask

    task automatic directed(input string nm, input logic [MW-1:0] m, input logic [EW-1:0] e,
                            input logic [EW-1:0] r, input logic [OW-1:0] xm, input bit xs,
                            input logic [EW-1:0] xe, input bit xi);
        beat_t p;
        int t;
        p = model(m, e, r, 0);
        check({nm, "_model_man"}, 64'(p.man), 64'(xm));
        check({nm, "_model_sticky"}, 64'(p.sticky), 64'(xs));
        send(m, e, r);
        t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 20) begin
            t++;
            @(negedge clk);
        end
        check({nm, "_wait"}, 64'(bus.out_valid), 64'(1));
        check({nm, "_man"}, 64'(bus.out_man), 64'(xm));
        check({nm, "_sticky"}, 64'(bus.out_sticky), 64'(xs));
        check({nm, "_exp"}, 64'(bus.out_exp), 64'(xe));
        check({nm, "_inv"}, 64'(bus.out_inv), 64'(xi));
        drain();
    endtask

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_man = '0;
        bus.in_exp = '0;
        bus.ref_exp = '0;

        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_man", 64'(bus.out_man), 64'(0));
        check("rst_out_sticky", 64'(bus.out_sticky), 64'(0));
        check("rst_out_exp", 64'(bus.out_exp), 64'(0));
        check("rst_out_inv", 64'(bus.out_inv), 64'(0));
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #2;
        rst = 1'b0;

        directed("shift2", 8'b1000_0000, 5'd3, 5'd5, 11'b001_0000_0000, 1'b0, 5'd5, 1'b0);
        directed("sticky5", 8'b1000_0001, 5'd2, 5'd7, 11'b000_0010_0000, STICKY, 5'd7, 1'b0);
        directed("sat", 8'h81, 5'd0, 5'd20, 11'd0, STICKY, 5'd20, 1'b0);
        directed("sat_zero", 8'h00, 5'd0, 5'd20, 11'd0, 1'b0, 5'd20, 1'b0);
        directed("inverted", 8'hC3, 5'd9, 5'd4, 11'b110_0001_1000, 1'b0, 5'd9, 1'b1);
        directed("edge10", 8'hFF, 5'd0, 5'd10, 11'b000_0000_0001, STICKY, 5'd10, 1'b0);

        // Back-to-back with out_ready high: the model demands one beat per cycle.
        mode = 0;
        for (int i = 0; i < 10; i++) send(MW'($urandom), EW'($urandom), EW'($urandom));
        drain();

        mode = 1;
        base = n_out;
        for (int i = 0; i < 10; i++) send(MW'($urandom), EW'($urandom), EW'($urandom));
        drain();
        check("bp_count", 64'(n_out - base), 64'(10));

        for (int i = 0; i < 150; i++) begin
            logic [EW-1:0] e;
            logic [EW-1:0] r;
            logic [MW-1:0] m;
            e = EW'($urandom);
            r = ($urandom_range(0, 9) < 7) ? EW'($urandom_range(int'(e), 31)) : EW'($urandom);
            m = ($urandom_range(0, 7) == 0) ? '0 : MW'($urandom);
            send(m, e, r);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #0;
        end
        mode = 0;
        drain();
        check("total_count", 64'(n_out), 64'(n_in));

        // Fill both stages under backpressure, then reset with beats in flight.
        mode = 2;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_man = MW'($urandom_range(1, 255));
            bus.in_exp = 5'd1;
            bus.ref_exp = 5'd3;
            @(posedge clk);
            #2;
        end
        check("full_in_ready", 64'(bus.in_ready), 64'(0));
        check("full_out_valid", 64'(bus.out_valid), 64'(1));
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_out_man", 64'(bus.out_man), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        mode = 0;
        @(negedge clk);
        check("postrst_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (8) @(negedge clk);
        check("postrst_no_beat", 64'(n_out), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
